// File: rtl/pipeline_hazard_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_if
// Bundles the hazard-unit signals exchanged between the five-stage pipeline
// and pipeline_hazard_ctrl.
//   slave  : hazard controller side (consumes stage info, drives stall/flush,
//            forward selects, timeout pulse and performance counters)
//   master : pipeline side (the mirror image)
// Signals:
//   Rs1D/Rs2D            decode-stage source registers
//   Rs1E/Rs2E/RdE        execute-stage sources and destination
//   MemReadE             execute-stage instruction is a load
//   MispredictE          execute-stage branch resolved against prediction
//   RdM/RegWriteM        memory-stage destination and write enable
//   RdW/RegWriteW        writeback-stage destination and write enable
//   MemReqM/MemReadyM    data-memory request and completion
//   StallF/D/E/M         hold pipeline registers
//   FlushD/E/W           bubble into pipeline registers
//   ForwardAE/BE         operand select: 00 regfile, 01 WB result, 10 M ALU
//   MemTimeout           one-cycle pulse on forced memory-stall release
//   StallCycles          saturating count of cycles with StallF asserted
//   FlushCount           saturating count of mispredict flush events
// -----------------------------------------------------------------------------
interface pipeline_hazard_if #(
  parameter int CNT_WIDTH = 32
);
  logic [4:0]           Rs1D;
  logic [4:0]           Rs2D;
  logic [4:0]           Rs1E;
  logic [4:0]           Rs2E;
  logic [4:0]           RdE;
  logic                 MemReadE;
  logic                 MispredictE;
  logic [4:0]           RdM;
  logic                 RegWriteM;
  logic [4:0]           RdW;
  logic                 RegWriteW;
  logic                 MemReqM;
  logic                 MemReadyM;

  logic                 StallF;
  logic                 StallD;
  logic                 StallE;
  logic                 StallM;
  logic                 FlushD;
  logic                 FlushE;
  logic                 FlushW;
  logic [1:0]           ForwardAE;
  logic [1:0]           ForwardBE;
  logic                 MemTimeout;
  logic [CNT_WIDTH-1:0] StallCycles;
  logic [CNT_WIDTH-1:0] FlushCount;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, MemReadE, MispredictE,
           RdM, RegWriteM, RdW, RegWriteW, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemTimeout, StallCycles, FlushCount
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, MemReadE, MispredictE,
           RdM, RegWriteM, RdW, RegWriteW, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemTimeout, StallCycles, FlushCount
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central hazard and stall controller for the five-stage pipeline: memory-wait
// stalls with bounded timeout, mispredict flushes, load-use stalls, execute
// operand forwarding and saturating stall/flush performance counters.
// Ports:
//   clk   clock
//   rst   asynchronous, active-high reset
//   hz    pipeline_hazard_if.slave (stage info in; stall/flush/forward,
//         MemTimeout and counters out)
// Parameters:
//   TIMEOUT    maximum memory-stall cycles before forced release (>= 2)
//   CNT_WIDTH  performance counter width (must match the interface)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | no outstanding memory miss; a new miss is detected here
// MEM_WAIT | miss outstanding; r_wait_cnt counts stall cycles spent so far
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT   = 64,
  parameter int CNT_WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  pipeline_hazard_if.slave hz
);

  localparam int             WCW      = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] WC_LIMIT = WCW'(TIMEOUT);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WCW-1:0]       r_wait_cnt;
  logic [WCW-1:0]       w_wait_cnt_nxt;
  logic [CNT_WIDTH-1:0] r_stall_cycles;
  logic [CNT_WIDTH-1:0] r_flush_count;

  logic       w_release;
  logic       w_mem_stall;
  logic       w_load_use;
  logic       w_flush_rule;
  logic       w_stall_f;
  logic       w_stall_d;
  logic       w_stall_e;
  logic       w_stall_m;
  logic       w_flush_d;
  logic       w_flush_e;
  logic       w_flush_w;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic       w_timeout;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (hz.RegWriteM && (hz.RdM != 5'd0) && (hz.RdM == rs)) begin
      return 2'b10;
    end else if (hz.RegWriteW && (hz.RdW != 5'd0) && (hz.RdW == rs)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  // Forced release: the wait budget is spent and memory is still not ready.
  assign w_release   = (r_state == MEM_WAIT) && !hz.MemReadyM && (r_wait_cnt == WC_LIMIT);
  assign w_mem_stall = hz.MemReqM && !hz.MemReadyM && !w_release;
  assign w_load_use  = hz.MemReadE && (hz.RdE != 5'd0) &&
                       ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  // A mispredict while E is frozen is deferred until the memory stall drops.
  assign w_flush_rule = !rst && !w_mem_stall && hz.MispredictE;

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      RUN: begin
        if (hz.MemReqM && !hz.MemReadyM) begin
          w_state_nxt    = MEM_WAIT;
          w_wait_cnt_nxt = WCW'(1);
        end
      end
      MEM_WAIT: begin
        if (hz.MemReadyM || (r_wait_cnt == WC_LIMIT)) begin
          w_state_nxt    = RUN;
          w_wait_cnt_nxt = '0;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WCW'(1);
        end
      end
      default: begin
        w_state_nxt    = RUN;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_stall_e = 1'b0;
    w_stall_m = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    w_flush_w = 1'b0;
    w_fwd_a   = 2'b00;
    w_fwd_b   = 2'b00;
    w_timeout = 1'b0;
    if (rst) begin
      // Bubbles everywhere while held in reset.
      w_flush_d = 1'b1;
      w_flush_e = 1'b1;
      w_flush_w = 1'b1;
    end else begin
      w_fwd_a   = fwd_sel(hz.Rs1E);
      w_fwd_b   = fwd_sel(hz.Rs2E);
      w_timeout = w_release;
      if (w_mem_stall) begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_stall_e = 1'b1;
        w_stall_m = 1'b1;
        w_flush_w = 1'b1;
      end else if (hz.MispredictE) begin
        w_flush_d = 1'b1;
        w_flush_e = 1'b1;
      end else if (w_load_use) begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_flush_e = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= RUN;
      r_wait_cnt     <= '0;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_stall_f && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
      end
      if (w_flush_rule && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + CNT_WIDTH'(1);
      end
    end
  end

  assign hz.StallF      = w_stall_f;
  assign hz.StallD      = w_stall_d;
  assign hz.StallE      = w_stall_e;
  assign hz.StallM      = w_stall_m;
  assign hz.FlushD      = w_flush_d;
  assign hz.FlushE      = w_flush_e;
  assign hz.FlushW      = w_flush_w;
  assign hz.ForwardAE   = w_fwd_a;
  assign hz.ForwardBE   = w_fwd_b;
  assign hz.MemTimeout  = w_timeout;
  assign hz.StallCycles = r_stall_cycles;
  assign hz.FlushCount  = r_flush_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int TO   = 4;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   chk_cnt  = 0;
  int   fail_cnt = 0;

  pipeline_hazard_if #(.CNT_WIDTH(CW)) hz ();

  pipeline_hazard_ctrl #(.TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  always #5 clk = ~clk;

  // Reference model: whether a miss is outstanding, how many stall cycles it
  // has already consumed, and the two event totals.
  bit m_wait;
  int m_used;
  int m_sc;
  int m_fc;

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,ForwardAE,ForwardBE,MemTimeout}
  localparam logic [11:0] RST_VEC = 12'b0000_111_00_00_0;

  logic [11:0] act;
  assign act = {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE,
                hz.FlushW, hz.ForwardAE, hz.ForwardBE, hz.MemTimeout};

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (rs == 0) return 2'b00;
    if (hz.RegWriteM && hz.RdM == rs) return 2'b10;
    if (hz.RegWriteW && hz.RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [11:0] exp_ctrl();
    bit budget_gone, mstall, lu;
    logic [3:0] st;
    logic [2:0] fl;
    if (rst) return RST_VEC;
    budget_gone = m_wait && !hz.MemReadyM && (m_used == TO);
    mstall = hz.MemReqM && !hz.MemReadyM && !budget_gone;
    lu = hz.MemReadE && hz.RdE != 0 && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
    if (mstall) begin st = 4'b1111; fl = 3'b001; end
    else if (hz.MispredictE) begin st = 4'b0000; fl = 3'b110; end
    else if (lu) begin st = 4'b1100; fl = 3'b010; end
    else begin st = 4'b0000; fl = 3'b000; end
    return {st, fl, exp_fwd(hz.Rs1E), exp_fwd(hz.Rs2E), budget_gone};
  endfunction

  task automatic clear_inputs();
    hz.Rs1D = 0; hz.Rs2D = 0; hz.Rs1E = 0; hz.Rs2E = 0; hz.RdE = 0;
    hz.MemReadE = 0; hz.MispredictE = 0; hz.RdM = 0; hz.RegWriteM = 0;
    hz.RdW = 0; hz.RegWriteW = 0; hz.MemReqM = 0; hz.MemReadyM = 0;
  endtask

  task automatic model_reset();
    m_wait = 0; m_used = 0; m_sc = 0; m_fc = 0;
  endtask

  // Advance one clock: update the model from the inputs the DUT sees at the edge.
  task automatic tick();
    logic [11:0] e;
    e = exp_ctrl();
    if (rst) begin
      model_reset();
    end else begin
      if (e[11] && m_sc < CMAX) m_sc++;
      if (e[7] && m_fc < CMAX) m_fc++;
      if (!m_wait) begin
        if (hz.MemReqM && !hz.MemReadyM) begin m_wait = 1; m_used = 1; end
      end else if (hz.MemReadyM || m_used == TO) begin
        m_wait = 0; m_used = 0;
      end else begin
        m_used++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    hz.MispredictE = 1; hz.MemReqM = 1; hz.RegWriteM = 1; hz.RdM = 3; hz.Rs1E = 3;
    @(negedge clk);
    chk_cnt++;
    if (act !== RST_VEC) begin
      fail_cnt++; $display("FAIL reset_outputs got=%b want=%b", act, RST_VEC);
    end
    chk_cnt++;
    if (hz.StallCycles !== 0 || hz.FlushCount !== 0) begin
      fail_cnt++; $display("FAIL reset_counters got=%0d/%0d want=0/0", hz.StallCycles, hz.FlushCount);
    end
    @(posedge clk); #1;
    model_reset();
    clear_inputs();
    rst = 0;
  endtask

  task automatic test_load_use();
    int sc0;
    sc0 = m_sc;
    clear_inputs();
    hz.MemReadE = 1; hz.RdE = 5; hz.Rs1D = 5;
    @(negedge clk);
    chk_cnt++;
    if (act !== 12'b1100_010_00_00_0 || act !== exp_ctrl()) begin
      fail_cnt++; $display("FAIL load_use got=%b want=%b", act, 12'b1100_010_00_00_0);
    end
    tick();
    hz.MemReadE = 0;
    @(negedge clk);
    chk_cnt++;
    if (act !== 12'b0 || hz.StallCycles !== CW'(sc0 + 1)) begin
      fail_cnt++; $display("FAIL load_use_after got=%b/%0d want=0/%0d", act, hz.StallCycles, sc0 + 1);
    end
    hz.MemReadE = 1; hz.RdE = 0; hz.Rs1D = 0; hz.Rs2D = 0;
    @(negedge clk);
    chk_cnt++;
    if (act !== 12'b0) begin
      fail_cnt++; $display("FAIL load_use_x0 got=%b want=0", act);
    end
    tick();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    hz.RdM = 7; hz.RegWriteM = 1; hz.RdW = 7; hz.RegWriteW = 1; hz.Rs1E = 7; hz.Rs2E = 7;
    @(negedge clk);
    chk_cnt++;
    if (hz.ForwardAE !== 2'b10 || hz.ForwardBE !== 2'b10) begin
      fail_cnt++; $display("FAIL fwd_m got=%b/%b want=10/10", hz.ForwardAE, hz.ForwardBE);
    end
    hz.RegWriteM = 0;
    #1;
    chk_cnt++;
    if (hz.ForwardAE !== 2'b01) begin
      fail_cnt++; $display("FAIL fwd_w got=%b want=01", hz.ForwardAE);
    end
    hz.Rs1E = 0; hz.RdW = 0;
    #1;
    chk_cnt++;
    if (hz.ForwardAE !== 2'b00 || hz.ForwardBE !== 2'b00) begin
      fail_cnt++; $display("FAIL fwd_none got=%b/%b want=00/00", hz.ForwardAE, hz.ForwardBE);
    end
    tick();
  endtask

  task automatic test_mispredict();
    int fc0;
    fc0 = m_fc;
    clear_inputs();
    hz.MispredictE = 1;
    @(negedge clk);
    chk_cnt++;
    if (act !== 12'b0000_110_00_00_0) begin
      fail_cnt++; $display("FAIL mispredict got=%b want=%b", act, 12'b0000_110_00_00_0);
    end
    tick();
    hz.MemReadE = 1; hz.RdE = 9; hz.Rs2D = 9;
    @(negedge clk);
    chk_cnt++;
    if (act !== 12'b0000_110_00_00_0 || hz.FlushCount !== CW'(fc0 + 1)) begin
      fail_cnt++; $display("FAIL mispredict_lu got=%b/%0d want=%b/%0d", act, hz.FlushCount, 12'b0000_110_00_00_0, fc0 + 1);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    chk_cnt++;
    if (hz.FlushCount !== CW'(fc0 + 2)) begin
      fail_cnt++; $display("FAIL flush_count got=%0d want=%0d", hz.FlushCount, fc0 + 2);
    end
    tick();
  endtask

  task automatic test_mem_stall();
    int sc0;
    sc0 = m_sc;
    clear_inputs();
    hz.MemReqM = 1;
    hz.MispredictE = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_cnt++;
      if (act !== 12'b1111_001_00_00_0) begin
        fail_cnt++; $display("FAIL mem_stall_c%0d got=%b want=%b", i, act, 12'b1111_001_00_00_0);
      end
      tick();
    end
    hz.MemReadyM = 1;
    @(negedge clk);
    chk_cnt++;
    if (act !== 12'b0000_110_00_00_0) begin
      fail_cnt++; $display("FAIL mem_ready_deferred_flush got=%b want=%b", act, 12'b0000_110_00_00_0);
    end
    tick();
    clear_inputs();
    hz.MemReqM = 1; hz.MemReadyM = 1;
    @(negedge clk);
    chk_cnt++;
    if (act !== 12'b0 || hz.StallCycles !== CW'(sc0 + 3)) begin
      fail_cnt++; $display("FAIL mem_done got=%b/%0d want=0/%0d", act, hz.StallCycles, sc0 + 3);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_timeout();
    int stalls;
    int pulse_at;
    stalls = 0; pulse_at = -1;
    clear_inputs();
    hz.MemReqM = 1;
    for (int i = 0; i < TO + 2; i++) begin
      @(negedge clk);
      chk_cnt++;
      if (act !== exp_ctrl()) begin
        fail_cnt++; $display("FAIL timeout_c%0d got=%b want=%b", i, act, exp_ctrl());
      end
      if (hz.StallF) stalls++;
      if (hz.MemTimeout && pulse_at < 0) pulse_at = i;
      tick();
    end
    chk_cnt++;
    // TO stalls, release without stall, then a fresh miss stalls again.
    if (stalls != TO + 1 || pulse_at != TO) begin
      fail_cnt++; $display("FAIL timeout_shape got=%0d stalls pulse@%0d want=%0d pulse@%0d", stalls, pulse_at, TO + 1, TO);
    end
    hz.MemReqM = 0; hz.MemReadyM = 1;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid_wait();
    int stalls;
    int pulses;
    stalls = 0; pulses = 0;
    clear_inputs();
    hz.MemReqM = 1;
    tick();
    tick();
    #2;
    rst = 1;
    #1;
    chk_cnt++;
    if (act !== RST_VEC || hz.StallCycles !== 0 || hz.FlushCount !== 0) begin
      fail_cnt++; $display("FAIL reset_mid_wait got=%b/%0d/%0d want=%b/0/0", act, hz.StallCycles, hz.FlushCount, RST_VEC);
    end
    @(posedge clk); #1;
    model_reset();
    rst = 0;
    for (int i = 0; i < TO + 1; i++) begin
      @(negedge clk);
      if (hz.StallF) stalls++;
      if (hz.MemTimeout) pulses++;
      tick();
    end
    chk_cnt++;
    if (stalls != TO || pulses != 1) begin
      fail_cnt++; $display("FAIL fresh_miss got=%0d stalls %0d pulses want=%0d/1", stalls, pulses, TO);
    end
    clear_inputs();
    hz.MemReadyM = 1;
    tick();
    clear_inputs();
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      hz.Rs1D = 5'($urandom_range(0, 3)); hz.Rs2D = 5'($urandom_range(0, 3));
      hz.Rs1E = 5'($urandom_range(0, 3)); hz.Rs2E = 5'($urandom_range(0, 3));
      hz.RdE  = 5'($urandom_range(0, 3)); hz.RdM  = 5'($urandom_range(0, 3));
      hz.RdW  = 5'($urandom_range(0, 3));
      hz.MemReadE    = ($urandom_range(0, 1) == 1);
      hz.MispredictE = ($urandom_range(0, 4) == 0);
      hz.RegWriteM   = ($urandom_range(0, 1) == 1);
      hz.RegWriteW   = ($urandom_range(0, 1) == 1);
      hz.MemReqM     = ($urandom_range(0, 2) != 0);
      hz.MemReadyM   = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      chk_cnt++;
      if (act !== exp_ctrl() || hz.StallCycles !== CW'(m_sc) || hz.FlushCount !== CW'(m_fc)) begin
        fail_cnt++;
        if (bad < 5)
          $display("FAIL random_c%0d got=%b/%0d/%0d want=%b/%0d/%0d", i, act, hz.StallCycles,
                   hz.FlushCount, exp_ctrl(), m_sc, m_fc);
        bad++;
      end
      tick();
    end
    clear_inputs();
    hz.MemReadyM = 1;
    tick();
    clear_inputs();
  endtask

  task automatic test_saturation();
    clear_inputs();
    hz.MemReadE = 1; hz.RdE = 4; hz.Rs1D = 4;
    for (int i = 0; i < CMAX + 10; i++) tick();
    hz.MispredictE = 1;
    for (int i = 0; i < CMAX + 10; i++) tick();
    clear_inputs();
    @(negedge clk);
    chk_cnt++;
    if (hz.StallCycles !== CW'(CMAX) || hz.FlushCount !== CW'(CMAX)) begin
      fail_cnt++; $display("FAIL saturation got=%0d/%0d want=%0d/%0d", hz.StallCycles, hz.FlushCount, CMAX, CMAX);
    end
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_load_use();
    test_forwarding();
    test_mispredict();
    test_mem_stall();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard and stall controller for the five-stage pipeline. It drives the stall and flush inputs of the fetch/decode, decode/execute, execute/memory and memory/writeback pipeline registers, and supplies the execute-stage forwarding selects. It sequences multi-cycle data-memory accesses with a bounded-wait state machine and keeps saturating stall and flush performance counters.

## Interface
- TIMEOUT, 64: maximum memory-stall cycles before forced release (≥2)
- CNT_WIDTH, 32: width of performance counters

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- Rs1D, Rs2D  in  5  decode-stage source registers
- Rs1E, Rs2E, RdE  in  5  execute-stage source and destination registers
- MemReadE  in  1  execute-stage instruction is a load
- MispredictE  in  1  execute-stage branch/jump resolved against prediction
- RdM  in  5  memory-stage destination; RegWriteM  in  1  memory-stage writes regfile
- RdW  in  5  writeback-stage destination; RegWriteW  in  1  writeback-stage writes regfile
- MemReqM  in  1  memory stage has an active load/store
- MemReadyM  in  1  data memory completes the access this cycle
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register
- FlushD, FlushE, FlushW  out  1  bubble into the corresponding pipeline register
- ForwardAE, ForwardBE  out  2  operand select: 00 regfile, 01 writeback result, 10 memory ALU result
- MemTimeout  out  1  one-cycle pulse on forced stall release
- StallCycles  out  CNT_WIDTH  cycles with StallF asserted
- FlushCount  out  CNT_WIDTH  mispredict flush events

## Operation
- FSM states: RUN, MEM_WAIT. Register wait_cnt, width $clog2(TIMEOUT+1).
- RUN: if MemReqM && !MemReadyM, go to MEM_WAIT with wait_cnt=1. Otherwise stay in RUN.
- MEM_WAIT, MemReadyM=1: go to RUN with wait_cnt=0. No stall this cycle.
- MEM_WAIT, MemReadyM=0, wait_cnt<TIMEOUT: stay and increment wait_cnt.
- MEM_WAIT, MemReadyM=0, wait_cnt==TIMEOUT: go to RUN, MemTimeout=1, no stall this cycle.
- mem_stall = MemReqM && !MemReadyM && !(state==MEM_WAIT && wait_cnt==TIMEOUT).
- Priority, highest first:
  1. mem_stall: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0. A mispredict is deferred because E is frozen. Load-use is ignored.
  2. MispredictE: FlushD=FlushE=1, all stalls 0. Any load-use in D is discarded.
  3. Load-use, defined as MemReadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D): StallF=StallD=1, FlushE=1.
  4. Otherwise all stall/flush outputs are 0.
- Forwarding, identical for A (Rs1E) and B (Rs2E):
  - 10 if RegWriteM && RdM!=0 && RdM==RsXE
  - else 01 if RegWriteW && RdW!=0 && RdW==RsXE
  - else 00
  - M has priority over W.
- StallCycles increments on each clock edge where StallF=1. FlushCount increments on each edge where rule 2 is active. Both saturate at all-ones.

## Timing
- Stall, flush and forward outputs are combinational from inputs and current state. The state, wait_cnt and counters are registered on posedge clk.
- Memory stall covers at most TIMEOUT cycles: the detection cycle in RUN plus TIMEOUT-1 cycles in MEM_WAIT. The release cycle carries no stall.
- A load-use hazard costs exactly 1 stall cycle. A mispredict costs 2 bubbles, in D and E.
- MemReadyM in the same cycle as the RUN-state request means no stall and no state change.
- MispredictE and mem_stall together: mispredict is applied on the first cycle after mem_stall drops, provided MispredictE is still held.
- While rst=1:
  - state=RUN, wait_cnt=0, counters=0
  - StallF/D/E/M=0, FlushD=FlushE=FlushW=1
  - ForwardAE=ForwardBE=00, MemTimeout=0
- Reset during MEM_WAIT abandons the wait immediately, with no MemTimeout pulse.

## Test plan
- Load x5 in E, decode reads Rs1D=5 → StallF=StallD=FlushE=1 for 1 cycle; StallCycles +1. Repeat with RdE=0 → no stall.
- RdM=7/RegWriteM=1 and RdW=7/RegWriteW=1, Rs1E=7 → ForwardAE=10. Drop RegWriteM → ForwardAE=01. Set Rs1E=0 → 00.
- MispredictE=1 alone → FlushD=FlushE=1, no stall; FlushCount 0→1. Combine with a load-use → still flush only, no stall.
- MemReqM=1, MemReadyM low for 3 cycles then high → StallF..StallM=1 and FlushW=1 for exactly 3 cycles; return to RUN; StallCycles=3.
- TIMEOUT=4, MemReadyM never high → 4 stall cycles, MemTimeout=1 on the 5th cycle with stalls low; state RUN.
- Assert rst mid-MEM_WAIT → stalls drop immediately, counters read 0, no MemTimeout. After release, a fresh miss restarts wait_cnt at 1.
